// File: rtl/irrigation_scheduler.sv
// Irrigation valve sequencer: permit debounce, minimum on-time, cooldown, latched sensor-conflict fault.
// Latency: valve opens DEBOUNCE_CYCLES+1 edges after permit is first sampled high; outputs are registered-state decodes.
// Backpressure: none; permit is a level request. Optional IRRIGATION_WATCHDOG_EN adds a MAX_ON_CYCLES run watchdog.
module irrigation_scheduler #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int MIN_ON_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int MAX_ON_CYCLES   = 64,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       irrigation_permit,
  input  logic       water_sensor_conflicting,
  input  logic       sprinkler_mode,
  input  logic       fault_clear,
  output logic       dripper_on,
  output logic       sprinkler_on,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] run_count,
  output logic       watchdog_trip
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_IRRIGATE = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

`ifdef IRRIGATION_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [7:0]       runs_q, runs_d;
  logic             wdt_q, wdt_d;

  // State, phase counter, latched valve mode, run counter and watchdog flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      runs_q  <= 8'd0;
      wdt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      runs_q  <= runs_d;
      wdt_q   <= wdt_d;
    end
  end

  // Next-state logic; a sensor conflict overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    runs_d  = runs_q;
    wdt_d   = wdt_q;
    if (water_sensor_conflicting) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (irrigation_permit) begin
            state_d = ST_ARM;
            cnt_d   = '0;
          end
        end
        ST_ARM: begin
          if (!irrigation_permit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_IRRIGATE;
            mode_d  = sprinkler_mode;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_IRRIGATE: begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (WD_EN && (cnt_q == WD_LAST)) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
            wdt_d   = 1'b1;
          end else if ((cnt_q >= MIN_LAST) && !irrigation_permit) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
            if (runs_q != 8'hFF) runs_d = runs_q + 8'd1;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q == COOL_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_FAULT: begin
          // Conflict is known low here, so an acknowledge is honoured.
          if (fault_clear) begin
            state_d = ST_COOLDOWN;
            cnt_d   = '0;
            wdt_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign state         = state_q;
  assign dripper_on    = (state_q == ST_IRRIGATE) && !mode_q;
  assign sprinkler_on  = (state_q == ST_IRRIGATE) && mode_q;
  assign fault         = (state_q == ST_FAULT);
  assign run_count     = runs_q;
  assign watchdog_trip = WD_EN & wdt_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with an expectation queue.
// Expectations are pushed as each step is driven and popped after the following edge.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_irrigation_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       irrigation_permit;
  logic       water_sensor_conflicting;
  logic       sprinkler_mode;
  logic       fault_clear;
  logic       dripper_on;
  logic       sprinkler_on;
  logic       fault;
  logic [2:0] state;
  logic [7:0] run_count;
  logic       watchdog_trip;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [13:0] vec;
  } exp_t;

  exp_t sb[$];

  irrigation_scheduler dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .irrigation_permit        (irrigation_permit),
    .water_sensor_conflicting (water_sensor_conflicting),
    .sprinkler_mode           (sprinkler_mode),
    .fault_clear              (fault_clear),
    .dripper_on               (dripper_on),
    .sprinkler_on             (sprinkler_on),
    .fault                    (fault),
    .state                    (state),
    .run_count                (run_count),
    .watchdog_trip            (watchdog_trip)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic [2:0] st, input logic d, input logic s,
                      input logic f, input logic [7:0] rc, input logic wd);
    exp_t e;
    e.tag = tag;
    e.vec = {st, d, s, f, rc, wd};
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [13:0] obs;
    e   = sb.pop_front();
    obs = {state, dripper_on, sprinkler_on, fault, run_count, watchdog_trip};
    checks++;
    assert (obs === e.vec) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (state,drip,spr,fault,runs,wd)", e.tag, obs, e.vec);
    end
  endtask

  // Expectation for the outputs after the next rising edge.
  task automatic step(input string tag, input logic [2:0] st, input logic d, input logic s,
                      input logic f, input logic [7:0] rc, input logic wd);
    push(tag, st, d, s, f, rc, wd);
    @(posedge clock);
    #1;
    pop_check();
  endtask

  // Expectation for the outputs right now, with no clock edge.
  task automatic now_chk(input string tag, input logic [2:0] st, input logic d, input logic s,
                         input logic f, input logic [7:0] rc, input logic wd);
    push(tag, st, d, s, f, rc, wd);
    pop_check();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    now_chk("reset_state", 3'd0, 0, 0, 0, 8'd0, 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n                  = 1'b0;
    irrigation_permit        = 1'b0;
    water_sensor_conflicting = 1'b0;
    sprinkler_mode           = 1'b0;
    fault_clear              = 1'b0;
    do_reset();

    // Dripper run: debounce, enter IRRIGATE, drop permit early, min on-time, cooldown.
    irrigation_permit = 1'b1;
    step("arm_c0", 3'd1, 0, 0, 0, 8'd0, 0);
    step("arm_c1", 3'd1, 0, 0, 0, 8'd0, 0);
    step("arm_c2", 3'd1, 0, 0, 0, 8'd0, 0);
    step("drip_open", 3'd2, 1, 0, 0, 8'd0, 0);
    step("irr_c1", 3'd2, 1, 0, 0, 8'd0, 0);
    step("irr_c2", 3'd2, 1, 0, 0, 8'd0, 0);
    irrigation_permit = 1'b0;
    for (int i = 3; i < 8; i++) step("min_on_hold", 3'd2, 1, 0, 0, 8'd0, 0);
    step("cool_enter", 3'd3, 0, 0, 0, 8'd1, 0);
    for (int i = 1; i < 4; i++) step("cool_hold", 3'd3, 0, 0, 0, 8'd1, 0);
    step("cool_exit", 3'd0, 0, 0, 0, 8'd1, 0);

    // Short permit pulse aborts ARM.
    irrigation_permit = 1'b1;
    step("pulse_arm0", 3'd1, 0, 0, 0, 8'd1, 0);
    step("pulse_arm1", 3'd1, 0, 0, 0, 8'd1, 0);
    irrigation_permit = 1'b0;
    step("pulse_idle", 3'd0, 0, 0, 0, 8'd1, 0);
    step("pulse_stay", 3'd0, 0, 0, 0, 8'd1, 0);

    // Sprinkler run, mode flip ignored, conflict fault and clear handshake.
    irrigation_permit = 1'b1;
    sprinkler_mode    = 1'b1;
    for (int i = 0; i < 3; i++) step("spr_arm", 3'd1, 0, 0, 0, 8'd1, 0);
    step("spr_open", 3'd2, 0, 1, 0, 8'd1, 0);
    sprinkler_mode = 1'b0;
    step("mode_flip_ign", 3'd2, 0, 1, 0, 8'd1, 0);
    water_sensor_conflicting = 1'b1;
    step("conflict_fault", 3'd4, 0, 0, 1, 8'd1, 0);
    fault_clear = 1'b1;
    step("clear_blocked", 3'd4, 0, 0, 1, 8'd1, 0);
    water_sensor_conflicting = 1'b0;
    step("clear_ok", 3'd3, 0, 0, 0, 8'd1, 0);
    fault_clear = 1'b0;
    irrigation_permit = 1'b0;
    for (int i = 1; i < 4; i++) step("post_fault_cool", 3'd3, 0, 0, 0, 8'd1, 0);
    step("post_fault_idle", 3'd0, 0, 0, 0, 8'd1, 0);
    water_sensor_conflicting = 1'b1;
    fault_clear = 1'b1;
    step("conflict_beats_clear", 3'd4, 0, 0, 1, 8'd1, 0);
    water_sensor_conflicting = 1'b0;
    step("idle_fault_clear", 3'd3, 0, 0, 0, 8'd1, 0);
    fault_clear = 1'b0;
    for (int i = 1; i < 4; i++) step("cool2_hold", 3'd3, 0, 0, 0, 8'd1, 0);
    step("cool2_exit", 3'd0, 0, 0, 0, 8'd1, 0);

    // Asynchronous reset mid-run closes the valve without an edge.
    irrigation_permit = 1'b1;
    sprinkler_mode    = 1'b1;
    for (int i = 0; i < 3; i++) step("rst_arm", 3'd1, 0, 0, 0, 8'd1, 0);
    step("rst_open", 3'd2, 0, 1, 0, 8'd1, 0);
    sprinkler_mode = 1'b0;
    step("rst_flip_ign", 3'd2, 0, 1, 0, 8'd1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    now_chk("async_reset", 3'd0, 0, 0, 0, 8'd0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Long run with permit held: watchdog fault when enabled, otherwise unbounded.
    irrigation_permit = 1'b1;
    sprinkler_mode    = 1'b0;
    for (int i = 0; i < 3; i++) step("wd_arm", 3'd1, 0, 0, 0, 8'd0, 0);
    step("wd_open", 3'd2, 1, 0, 0, 8'd0, 0);
    for (int i = 1; i < 64; i++) step("wd_run", 3'd2, 1, 0, 0, 8'd0, 0);
`ifdef IRRIGATION_WATCHDOG_EN
    step("wd_trip", 3'd4, 0, 0, 1, 8'd0, 1);
    step("wd_fault_hold", 3'd4, 0, 0, 1, 8'd0, 1);
    irrigation_permit = 1'b0;
    fault_clear       = 1'b1;
    step("wd_clear", 3'd3, 0, 0, 0, 8'd0, 0);
    fault_clear = 1'b0;
`else
    step("no_wd_run", 3'd2, 1, 0, 0, 8'd0, 0);
    step("no_wd_run2", 3'd2, 1, 0, 0, 8'd0, 0);
    irrigation_permit = 1'b0;
    step("no_wd_end", 3'd3, 0, 0, 0, 8'd1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
